// File: rtl/decode_top.sv
// rtl/decode_top.sv - MIPS decode stage: f2d/d2f/d2e 4-phase handshakes, 32x32 register file, redirect decode
module decode_top #(
    parameter int SYNC_STAGES = 2,
    parameter int RF_DEPTH    = 32
) (
    input  logic         CLK,
    input  logic         Z_R,
    input  logic         f2d_R,
    input  logic [63:0]  f2d,
    output logic         f2d_A,
    input  logic         d2f_R,
    output logic [32:0]  d2f,
    output logic         d2f_A,
    output logic         d2e_R,
    output logic [127:0] d2e,
    input  logic         d2e_A,
    input  logic         WB_EN,
    input  logic [4:0]   WB_ADDR,
    input  logic [31:0]  WB_DATA
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        F_REL   = 3'd1,
        DEC     = 3'd2,
        W_D2F   = 3'd3,
        D2F_REL = 3'd4,
        W_EA    = 3'd5,
        W_ER    = 3'd6
    } state_t;

    state_t state_q, state_d;

    // Handshake synchronizer chains; the last stage is the value the FSM sees.
    logic [SYNC_STAGES-1:0] f2d_sync_q, f2d_sync_d;
    logic [SYNC_STAGES-1:0] d2f_sync_q, d2f_sync_d;
    logic [SYNC_STAGES-1:0] d2e_sync_q, d2e_sync_d;
    // Fills with ones after reset; once full, the f2d_R chain carries a real sample.
    logic [SYNC_STAGES-1:0] f2d_vld_q, f2d_vld_d;

    // A new instruction is accepted only after f2d_R has been genuinely seen low,
    // so a request left high across a reset is not mistaken for a fresh one.
    logic f2d_arm_q, f2d_arm_d;

    logic         f2d_A_q, f2d_A_d;
    logic         d2f_A_q, d2f_A_d;
    logic         d2e_R_q, d2e_R_d;
    logic [32:0]  d2f_q, d2f_d;
    logic [127:0] d2e_q, d2e_d;
    logic [31:0]  npc_q, npc_d;
    logic [31:0]  instr_q, instr_d;

    logic [31:0] rf_q [RF_DEPTH];
    logic [31:0] rf_d [RF_DEPTH];

    logic        f2d_seen, d2f_seen, d2e_seen, f2d_valid;
    logic [4:0]  rs_idx, rt_idx;
    logic [31:0] rs_val, rt_val;
    logic [5:0]  op, funct;
    logic [31:0] br_off, br_tgt;
    logic        taken;
    logic [31:0] target;

    assign f2d_seen  = f2d_sync_q[SYNC_STAGES-1];
    assign d2f_seen  = d2f_sync_q[SYNC_STAGES-1];
    assign d2e_seen  = d2e_sync_q[SYNC_STAGES-1];
    assign f2d_valid = f2d_vld_q[SYNC_STAGES-1];

    assign f2d_A = f2d_A_q;
    assign d2f_A = d2f_A_q;
    assign d2e_R = d2e_R_q;
    assign d2f   = d2f_q;
    assign d2e   = d2e_q;

    // Shift each handshake input one stage deeper per clock.
    always_comb begin
        f2d_sync_d = {f2d_sync_q[SYNC_STAGES-2:0], f2d_R};
        d2f_sync_d = {d2f_sync_q[SYNC_STAGES-2:0], d2f_R};
        d2e_sync_d = {d2e_sync_q[SYNC_STAGES-2:0], d2e_A};
        f2d_vld_d  = {f2d_vld_q[SYNC_STAGES-2:0], 1'b1};
    end

    // Register file write port; r0 is never written so it always reads zero.
    always_comb begin
        rf_d = rf_q;
        if (WB_EN && (WB_ADDR != 5'd0)) begin
            rf_d[WB_ADDR] = WB_DATA;
        end
    end

    // Operand read with same-cycle writeback bypass.
    always_comb begin
        rs_idx = instr_q[25:21];
        rt_idx = instr_q[20:16];
        rs_val = rf_q[rs_idx];
        rt_val = rf_q[rt_idx];
        if (WB_EN && (WB_ADDR != 5'd0) && (WB_ADDR == rs_idx)) begin
            rs_val = WB_DATA;
        end
        if (WB_EN && (WB_ADDR != 5'd0) && (WB_ADDR == rt_idx)) begin
            rt_val = WB_DATA;
        end
    end

    // Redirect decode: jumps, conditional branches and JR; untaken reports target 0.
    always_comb begin
        op     = instr_q[31:26];
        funct  = instr_q[5:0];
        br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        br_tgt = npc_q + br_off;
        taken  = 1'b0;
        target = 32'd0;
        case (op)
            6'd2, 6'd3: begin
                taken  = 1'b1;
                target = {npc_q[31:28], instr_q[25:0], 2'b00};
            end
            6'd4: begin
                if (rs_val == rt_val) begin
                    taken  = 1'b1;
                    target = br_tgt;
                end
            end
            6'd5: begin
                if (rs_val != rt_val) begin
                    taken  = 1'b1;
                    target = br_tgt;
                end
            end
            6'd0: begin
                if (funct == 6'd8) begin
                    taken  = 1'b1;
                    target = rs_val;
                end
            end
            default: begin
                taken  = 1'b0;
                target = 32'd0;
            end
        endcase
    end

    // Handshake sequencer: one instruction from fetch, one redirect answer, one push to execute.
    always_comb begin
        state_d   = state_q;
        f2d_A_d   = f2d_A_q;
        d2f_A_d   = d2f_A_q;
        d2e_R_d   = d2e_R_q;
        d2f_d     = d2f_q;
        d2e_d     = d2e_q;
        npc_d     = npc_q;
        instr_d   = instr_q;
        f2d_arm_d = f2d_arm_q;
        if (f2d_valid && !f2d_seen) begin
            f2d_arm_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (f2d_seen && f2d_arm_q) begin
                    npc_d     = f2d[63:32];
                    instr_d   = f2d[31:0];
                    f2d_A_d   = 1'b1;
                    f2d_arm_d = 1'b0;
                    state_d   = F_REL;
                end
            end
            F_REL: begin
                if (!f2d_seen) begin
                    f2d_A_d = 1'b0;
                    state_d = DEC;
                end
            end
            DEC: begin
                d2f_d   = {taken, target};
                d2e_d   = {npc_q, rs_val, rt_val, instr_q};
                state_d = W_D2F;
            end
            W_D2F: begin
                if (d2f_seen) begin
                    d2f_A_d = 1'b1;
                    state_d = D2F_REL;
                end
            end
            D2F_REL: begin
                if (!d2f_seen) begin
                    d2f_A_d = 1'b0;
                    d2e_R_d = 1'b1;
                    state_d = W_EA;
                end
            end
            W_EA: begin
                if (d2e_seen) begin
                    d2e_R_d = 1'b0;
                    state_d = W_ER;
                end
            end
            W_ER: begin
                if (!d2e_seen) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, output and register file flops; reset aborts any transaction in flight.
    always_ff @(posedge CLK or posedge Z_R) begin
        if (Z_R) begin
            state_q    <= IDLE;
            f2d_sync_q <= '0;
            d2f_sync_q <= '0;
            d2e_sync_q <= '0;
            f2d_vld_q  <= '0;
            f2d_arm_q  <= 1'b0;
            f2d_A_q    <= 1'b0;
            d2f_A_q    <= 1'b0;
            d2e_R_q    <= 1'b0;
            d2f_q      <= '0;
            d2e_q      <= '0;
            npc_q      <= '0;
            instr_q    <= '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            f2d_sync_q <= f2d_sync_d;
            d2f_sync_q <= d2f_sync_d;
            d2e_sync_q <= d2e_sync_d;
            f2d_vld_q  <= f2d_vld_d;
            f2d_arm_q  <= f2d_arm_d;
            f2d_A_q    <= f2d_A_d;
            d2f_A_q    <= d2f_A_d;
            d2e_R_q    <= d2e_R_d;
            d2f_q      <= d2f_d;
            d2e_q      <= d2e_d;
            npc_q      <= npc_d;
            instr_q    <= instr_d;
            rf_q       <= rf_d;
        end
    end

endmodule

// File: tb/tb_decode_top.sv
// tb/tb_decode_top.sv - self-checking bench for decode_top
module tb_decode_top;

    logic         CLK = 1'b0;
    logic         Z_R;
    logic         f2d_R;
    logic [63:0]  f2d;
    logic         f2d_A;
    logic         d2f_R;
    logic [32:0]  d2f;
    logic         d2f_A;
    logic         d2e_R;
    logic [127:0] d2e;
    logic         d2e_A;
    logic         WB_EN;
    logic [4:0]   WB_ADDR;
    logic [31:0]  WB_DATA;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] shadow [32];

    typedef struct {
        logic [31:0] npc;
        logic [31:0] instr;
        logic [4:0]  pre_a;
        logic [31:0] pre_d;
        bit          byp;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic [32:0] exp_r;
    } vec_t;

    vec_t tab [9];

    decode_top #(.SYNC_STAGES(2), .RF_DEPTH(32)) dut (
        .CLK(CLK), .Z_R(Z_R),
        .f2d_R(f2d_R), .f2d(f2d), .f2d_A(f2d_A),
        .d2f_R(d2f_R), .d2f(d2f), .d2f_A(d2f_A),
        .d2e_R(d2e_R), .d2e(d2e), .d2e_A(d2e_A),
        .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Redirect rules written as plain arithmetic on the instruction fields.
    function automatic logic [32:0] ref_redirect(input logic [31:0] npc, input logic [31:0] instr,
                                                 input logic [31:0] rsv, input logic [31:0] rtv);
        int unsigned opc;
        int unsigned fn;
        logic signed [31:0] off;
        logic [31:0] btgt;
        opc  = instr >> 26;
        fn   = instr & 32'h3F;
        off  = $signed(instr[15:0]);
        btgt = npc + off * 4;
        if (opc == 2 || opc == 3) return {1'b1, (npc & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 4)};
        if (opc == 4) return (rsv == rtv) ? {1'b1, btgt} : 33'd0;
        if (opc == 5) return (rsv != rtv) ? {1'b1, btgt} : 33'd0;
        if (opc == 0 && fn == 8) return {1'b1, rsv};
        return 33'd0;
    endfunction

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return f2d_A;
            1:       return d2f_A;
            default: return d2e_R;
        endcase
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_for(input int sel, input logic val, input string nm);
        int n = 0;
        while (get_sig(sel) !== val && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got timeout expected level %0d", nm, val);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        WB_EN = 1'b1; WB_ADDR = a; WB_DATA = d;
        @(posedge CLK);
        @(negedge CLK);
        WB_EN = 1'b0;
        if (a != 5'd0) shadow[a] = d;
    endtask

    task automatic run_instr(input logic [31:0] npc, input logic [31:0] instr,
                             input bit byp, input logic [4:0] ba, input logic [31:0] bd,
                             input bit use_model, input logic [32:0] exp_tab,
                             input int hold, input bit early, input logic [63:0] nxt,
                             input bit early_pull, input string tag);
        logic [31:0]  rsv, rtv;
        logic [32:0]  exp_r;
        logic [127:0] exp_e, snap;
        bit ok;
        if (byp && ba != 5'd0) shadow[ba] = bd;
        rsv   = shadow[instr[25:21]];
        rtv   = shadow[instr[20:16]];
        exp_r = use_model ? ref_redirect(npc, instr, rsv, rtv) : exp_tab;
        exp_e = {npc, rsv, rtv, instr};
        f2d = {npc, instr};
        f2d_R = 1'b1;
        if (early_pull) d2f_R = 1'b1;
        wait_for(0, 1'b1, {tag, "_f2dA_rise"});
        if (early_pull) check({tag, "_pull_pending"}, {127'd0, d2f_A}, 128'd0);
        f2d_R = 1'b0;
        wait_for(0, 1'b0, {tag, "_f2dA_fall"});
        if (byp) begin
            WB_EN = 1'b1; WB_ADDR = ba; WB_DATA = bd;
            @(posedge CLK);
            #1;
            WB_EN = 1'b0;
        end
        d2f_R = 1'b1;
        wait_for(1, 1'b1, {tag, "_d2fA_rise"});
        check({tag, "_d2f"}, {95'd0, d2f}, {95'd0, exp_r});
        check({tag, "_d2e"}, d2e, exp_e);
        check({tag, "_d2eR_low_in_d2f"}, {127'd0, d2e_R}, 128'd0);
        d2f_R = 1'b0;
        wait_for(1, 1'b0, {tag, "_d2fA_fall"});
        check({tag, "_d2eR_after_d2fA"}, {127'd0, d2e_R}, 128'd1);
        if (hold > 0) begin
            snap = d2e;
            if (early) begin
                f2d = nxt;
                f2d_R = 1'b1;
            end
            ok = 1'b1;
            repeat (hold) begin
                @(negedge CLK);
                if (d2e_R !== 1'b1 || d2e !== snap || f2d_A !== 1'b0 || d2f !== exp_r) ok = 1'b0;
            end
            check({tag, "_backpressure_hold"}, {127'd0, ok}, 128'd1);
        end
        d2e_A = 1'b1;
        wait_for(2, 1'b0, {tag, "_d2eR_fall"});
        if (early) check({tag, "_no_ack_before_d2eA_fall"}, {127'd0, f2d_A}, 128'd0);
        d2e_A = 1'b0;
    endtask

    initial begin
        logic [31:0] rv [5];
        logic [4:0]  ra [5];
        bit ok;
        Z_R = 1'b1; f2d_R = 1'b0; f2d = '0; d2f_R = 1'b0; d2e_A = 1'b0;
        WB_EN = 1'b0; WB_ADDR = '0; WB_DATA = '0;
        for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
        ra[0] = 5'd0; ra[1] = 5'd1; ra[2] = 5'd2; ra[3] = 5'd3; ra[4] = 5'd31;

        tab[0] = '{32'h0040_0004, 32'h0810_0010, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, {1'b1, 32'h0040_0040}};
        tab[1] = '{32'h0000_0100, {6'd4, 5'd1, 5'd2, 16'hFFFE}, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, {1'b1, 32'h0000_00F8}};
        tab[2] = '{32'h0000_0100, {6'd4, 5'd1, 5'd2, 16'hFFFE}, 5'd2, 32'd6, 1'b0, 5'd0, 32'd0, 33'd0};
        tab[3] = '{32'h0000_1000, {6'd5, 5'd1, 5'd2, 16'h0010}, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, {1'b1, 32'h0000_1040}};
        tab[4] = '{32'h0000_0500, {6'd0, 5'd31, 15'd0, 6'd8}, 5'd0, 32'd0, 1'b1, 5'd31, 32'h0000_2000, {1'b1, 32'h0000_2000}};
        tab[5] = '{32'h0000_0600, {6'd0, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20}, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 33'd0};
        tab[6] = '{32'hA000_0000, {6'd3, 26'h3FF_FFFF}, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, {1'b1, 32'hAFFF_FFFC}};
        tab[7] = '{32'hFFFF_FFF0, {6'd4, 5'd1, 5'd1, 16'h0008}, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, {1'b1, 32'h0000_0010}};
        tab[8] = '{32'h0000_0200, {6'd4, 5'd2, 5'd1, 16'h0001}, 5'd0, 32'd0, 1'b1, 5'd2, 32'd5, {1'b1, 32'h0000_0204}};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs", {f2d_A, d2f_A, d2e_R, d2f, d2e[91:0]}, '0);
        check("reset_d2e_hi", {92'd0, d2e[127:92]}, '0);
        Z_R = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset during F_REL with the request still held high.
        f2d = {32'h0000_0040, 32'h0810_0010};
        f2d_R = 1'b1;
        wait_for(0, 1'b1, "rst_f2dA_rise");
        #2 Z_R = 1'b1;
        #1 check("rst_async_f2dA", {127'd0, f2d_A}, 128'd0);
        for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
        @(negedge CLK);
        Z_R = 1'b0;
        d2f_R = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            if (f2d_A !== 1'b0 || d2f_A !== 1'b0 || d2e_R !== 1'b0) ok = 1'b0;
        end
        check("rst_quiet_after_release", {127'd0, ok}, 128'd1);
        f2d_R = 1'b0; d2f_R = 1'b0;
        repeat (5) @(negedge CLK);
        run_instr(32'h0000_0080, {6'd0, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20}, 1'b0, 5'd0, 32'd0,
                  1'b0, 33'd0, 0, 1'b0, 64'd0, 1'b0, "post_rst_add");

        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd5);
        for (int i = 0; i < 9; i++) begin
            if (tab[i].pre_a != 5'd0 || tab[i].pre_d != 32'd0) write_reg(tab[i].pre_a, tab[i].pre_d);
            run_instr(tab[i].npc, tab[i].instr, tab[i].byp, tab[i].ba, tab[i].bd,
                      1'b0, tab[i].exp_r, 0, 1'b0, 64'd0, 1'b0, $sformatf("tab%0d", i));
        end

        // Execute back-pressure with the next fetch request already waiting.
        run_instr(32'h0000_0300, 32'h0810_0010, 1'b0, 5'd0, 32'd0, 1'b1, 33'd0,
                  50, 1'b1, {32'h0000_0304, {6'd5, 5'd1, 5'd2, 16'h0004}}, 1'b0, "bp");
        run_instr(32'h0000_0304, {6'd5, 5'd1, 5'd2, 16'h0004}, 1'b0, 5'd0, 32'd0, 1'b1, 33'd0,
                  0, 1'b0, 64'd0, 1'b1, "bp_next");

        for (int it = 0; it < 40; it++) begin
            logic [31:0] ins, npc, wd;
            logic [4:0]  rs, rt, wa;
            int k;
            rv[0] = 32'd5; rv[1] = 32'd6; rv[2] = $urandom; rv[3] = 32'd0; rv[4] = 32'd5;
            if ($urandom_range(1, 0) == 1) write_reg(ra[$urandom_range(4, 0)], rv[$urandom_range(4, 0)]);
            rs  = ra[$urandom_range(4, 0)];
            rt  = ra[$urandom_range(4, 0)];
            npc = $urandom & 32'hFFFF_FFFC;
            k   = $urandom_range(6, 0);
            case (k)
                0: ins = {6'd2, 26'($urandom)};
                1: ins = {6'd3, 26'($urandom)};
                2: ins = {6'd4, rs, rt, 16'($urandom)};
                3: ins = {6'd5, rs, rt, 16'($urandom)};
                4: ins = {6'd0, rs, 15'd0, 6'd8};
                5: ins = {6'd0, rs, rt, 5'd4, 5'd0, 6'h20};
                default: ins = $urandom;
            endcase
            wa = ra[$urandom_range(4, 0)];
            wd = rv[$urandom_range(4, 0)];
            run_instr(npc, ins, ($urandom_range(3, 0) == 0), wa, wd, 1'b1, 33'd0,
                      0, 1'b0, 64'd0, ($urandom_range(1, 0) == 1), $sformatf("rnd%0d", it));
        end

        repeat (5) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
